// File: rtl/flex_counter_array_if.sv
// rtl/flex_counter_array_if.sv - control and status bundle for the flex counter bank
interface flex_counter_array_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2
);
    logic [NUM_CH-1:0]              clear;
    logic [NUM_CH-1:0]              count_enable;
    logic [NUM_CH-1:0]              count_down;
    logic [NUM_CH-1:0]              one_shot;
    logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
    logic [NUM_CH-1:0]              rollover_flag;
    logic [NUM_CH-1:0]              rollover_pulse;
    logic [NUM_CH-1:0]              done;
    logic                           any_rollover;

    modport master (
        output clear, count_enable, count_down, one_shot, rollover_val,
        input  count_out, rollover_flag, rollover_pulse, done, any_rollover
    );

    modport slave (
        input  clear, count_enable, count_down, one_shot, rollover_val,
        output count_out, rollover_flag, rollover_pulse, done, any_rollover
    );
endinterface

// File: rtl/flex_counter_array.sv
// rtl/flex_counter_array.sv - bank of independent up/down, periodic/one-shot counters
module flex_counter_array #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    flex_counter_array_if.slave  bus
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CH-1:0] pulse_vec;

    assign bus.any_rollover = |pulse_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [NUM_CNT_BITS-1:0] r;
        logic [NUM_CNT_BITS-1:0] term;
        logic [NUM_CNT_BITS-1:0] c_q;
        logic [NUM_CNT_BITS-1:0] c_nxt;
        logic                    flag_q;
        logic                    flag_nxt;
        logic                    pulse_q;
        logic                    pulse_nxt;
        logic                    done_q;
        logic                    done_nxt;
        logic                    step;

        assign r = bus.rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];

        always_comb begin
            step      = 1'b0;
            c_nxt     = c_q;
            flag_nxt  = 1'b0;
            pulse_nxt = 1'b0;
            done_nxt  = done_q;
            term      = bus.count_down[i] ? ONE : r;
            if (bus.clear[i]) begin
                c_nxt    = '0;
                done_nxt = 1'b0;
            end else begin
                // A halted one-shot or a disabled (R == 0) channel never steps.
                step = bus.count_enable[i] && !done_q && (r != '0);
                if (step) begin
                    if (bus.count_down[i]) begin
                        c_nxt = ((c_q <= ONE) || (c_q > r)) ? r : c_q - ONE;
                    end else begin
                        c_nxt = (c_q >= r) ? ONE : c_q + ONE;
                    end
                end
                // Flag is re-evaluated on hold cycles too, so R/direction edits show next cycle.
                flag_nxt  = (r != '0) && (c_nxt == term);
                pulse_nxt = step && (c_nxt == term);
                if (pulse_nxt && bus.one_shot[i]) begin
                    done_nxt = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                c_q     <= '0;
                flag_q  <= 1'b0;
                pulse_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                c_q     <= c_nxt;
                flag_q  <= flag_nxt;
                pulse_q <= pulse_nxt;
                done_q  <= done_nxt;
            end
        end

        assign bus.count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS] = c_q;
        assign bus.rollover_flag[i]  = flag_q;
        assign bus.rollover_pulse[i] = pulse_q;
        assign bus.done[i]           = done_q;
        assign pulse_vec[i]          = pulse_q;
    end
endmodule

// File: tb/tb_flex_counter_array.sv
// tb/tb_flex_counter_array.sv - randomized and directed checks against a behavioural counter model
module tb_flex_counter_array;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flex_counter_array_if #(.NUM_CNT_BITS(W), .NUM_CH(N)) bus ();

    flex_counter_array #(.NUM_CNT_BITS(W), .NUM_CH(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int m_c     [N];
    int m_flag  [N];
    int m_pulse [N];
    int m_done  [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            m_c[ch] = 0; m_flag[ch] = 0; m_pulse[ch] = 0; m_done[ch] = 0;
        end
    endtask

    // Spec-level rules evaluated on the inputs present at the rising edge.
    task automatic model_edge();
        for (int ch = 0; ch < N; ch++) begin
            int r, c, t, step;
            r = int'(bus.rollover_val[ch*W +: W]);
            c = m_c[ch];
            if (bus.clear[ch]) begin
                m_c[ch] = 0; m_flag[ch] = 0; m_pulse[ch] = 0; m_done[ch] = 0;
            end else begin
                step = (bus.count_enable[ch] && m_done[ch] == 0 && r != 0) ? 1 : 0;
                if (step == 1) begin
                    if (bus.count_down[ch]) c = (c <= 1 || c > r) ? r : c - 1;
                    else                    c = (c >= r) ? 1 : (c + 1) % (1 << W);
                end
                t = bus.count_down[ch] ? 1 : r;
                m_c[ch]     = c;
                m_flag[ch]  = (r != 0 && c == t) ? 1 : 0;
                m_pulse[ch] = (step == 1 && c == t) ? 1 : 0;
                if (m_pulse[ch] == 1 && bus.one_shot[ch]) m_done[ch] = 1;
            end
        end
    endtask

    task automatic check_all();
        int any;
        any = 0;
        for (int ch = 0; ch < N; ch++) begin
            chk($sformatf("cnt%0d", ch),   bus.count_out[ch*W +: W], m_c[ch]);
            chk($sformatf("flag%0d", ch),  bus.rollover_flag[ch],    m_flag[ch]);
            chk($sformatf("pulse%0d", ch), bus.rollover_pulse[ch],   m_pulse[ch]);
            chk($sformatf("done%0d", ch),  bus.done[ch],             m_done[ch]);
            any = any | m_pulse[ch];
        end
        chk("any_rollover", bus.any_rollover, any);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_r(input int ch, input int val);
        bus.rollover_val[ch*W +: W] = W'(val);
    endtask

    task automatic clear_all();
        bus.clear = '1;
        tick();
        bus.clear = '0;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_cnt", bus.count_out, 0);
        chk("async_rst_flags", {bus.rollover_flag, bus.rollover_pulse, bus.done, bus.any_rollover}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_c [6];
        int exp_f [6];
        int np2, np3;

        rst               = 1'b1;
        bus.clear         = '0;
        bus.count_enable  = '0;
        bus.count_down    = '0;
        bus.one_shot      = '0;
        bus.rollover_val  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Reset mid-count, then periodic up with R=5
        set_r(0, 5);
        bus.count_enable[0] = 1'b1;
        repeat (3) tick();
        chk("pre_rst_c3", bus.count_out[0 +: W], 3);
        pulse_reset();
        exp_c = '{1, 2, 3, 4, 5, 1};
        exp_f = '{0, 0, 0, 0, 1, 0};
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("up5_c", bus.count_out[0 +: W], exp_c[k]);
            chk("up5_flag", bus.rollover_flag[0], exp_f[k]);
            chk("up5_pulse", bus.rollover_pulse[0], exp_f[k]);
        end
        bus.count_enable[0] = 1'b0;
        clear_all();

        // Down count on ch1, R=3
        set_r(1, 3);
        bus.count_down[1]   = 1'b1;
        bus.count_enable[1] = 1'b1;
        exp_c = '{3, 2, 1, 3, 2, 1};
        exp_f = '{0, 0, 1, 0, 0, 1};
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("dn3_c", bus.count_out[W +: W], exp_c[k]);
            chk("dn3_flag", bus.rollover_flag[1], exp_f[k]);
            chk("dn3_pulse", bus.rollover_pulse[1], exp_f[k]);
            chk("dn3_any", bus.any_rollover, exp_f[k]);
        end
        bus.count_enable[1] = 1'b0;
        bus.count_down[1]   = 1'b0;
        set_r(1, 0);
        clear_all();

        // One-shot up, R=4
        set_r(0, 4);
        bus.one_shot[0]     = 1'b1;
        bus.count_enable[0] = 1'b1;
        exp_c = '{1, 2, 3, 4, 4, 4};
        exp_f = '{0, 0, 0, 1, 1, 1};
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("os_c", bus.count_out[0 +: W], exp_c[k]);
            chk("os_done", bus.done[0], exp_f[k]);
            chk("os_pulse", bus.rollover_pulse[0], (k == 3) ? 1 : 0);
        end
        bus.one_shot[0] = 1'b0;
        tick();
        chk("os_hold_c", bus.count_out[0 +: W], 4);
        chk("os_hold_done", bus.done[0], 1);
        bus.clear[0] = 1'b1;
        tick();
        chk("os_clr_c", bus.count_out[0 +: W], 0);
        chk("os_clr_done", bus.done[0], 0);
        bus.clear[0] = 1'b0;
        tick();
        chk("os_resume_c", bus.count_out[0 +: W], 1);

        // Clear priority at C=4, R=5; then R=1 periodic
        clear_all();
        set_r(0, 5);
        repeat (4) tick();
        chk("clrp_pre_c", bus.count_out[0 +: W], 4);
        bus.clear[0] = 1'b1;
        tick();
        chk("clrp_c", bus.count_out[0 +: W], 0);
        chk("clrp_flag", bus.rollover_flag[0], 0);
        bus.clear[0] = 1'b0;
        set_r(0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r1_c", bus.count_out[0 +: W], 1);
            chk("r1_pulse", bus.rollover_pulse[0], 1);
        end

        // R boundaries
        clear_all();
        set_r(0, 0);
        repeat (3) tick();
        chk("r0_c", bus.count_out[0 +: W], 0);
        chk("r0_flag", bus.rollover_flag[0], 0);
        set_r(0, 9);
        repeat (7) tick();
        chk("r9_c7", bus.count_out[0 +: W], 7);
        set_r(0, 3);
        tick();
        chk("r9to3_c", bus.count_out[0 +: W], 1);

        // Channel isolation at full 8-bit range
        bus.count_enable = '0;
        set_r(0, 0);
        clear_all();
        set_r(2, 255);
        set_r(3, 255);
        bus.count_down[3] = 1'b1;
        bus.count_enable  = 4'b1100;
        np2 = 0; np3 = 0;
        for (int k = 0; k < 260; k++) begin
            tick();
            np2 += int'(bus.rollover_pulse[2]);
            np3 += int'(bus.rollover_pulse[3]);
            if (k == 255) begin
                chk("iso_ch2_wrap", bus.count_out[2*W +: W], 1);
                chk("iso_ch3_wrap", bus.count_out[3*W +: W], 255);
            end
        end
        chk("iso_ch2_pulses", np2, 1);
        chk("iso_ch3_pulses", np3, 1);
        chk("iso_idle", bus.count_out[0 +: 2*W], 0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            for (int ch = 0; ch < N; ch++) begin
                bus.clear[ch]        = ($urandom_range(0, 15) == 0);
                bus.count_enable[ch] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) bus.count_down[ch] = ~bus.count_down[ch];
                if ($urandom_range(0, 7) == 0) bus.one_shot[ch]   = ~bus.one_shot[ch];
                if ($urandom_range(0, 11) == 0) begin
                    case ($urandom_range(0, 6))
                        0: set_r(ch, 0);
                        1: set_r(ch, 1);
                        2: set_r(ch, 2);
                        3: set_r(ch, 5);
                        4: set_r(ch, 255);
                        default: set_r(ch, int'($urandom_range(0, 255)));
                    endcase
                end
            end
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/flex_counter_array.md
# flex_counter_array

Multi-channel successor to the team's single flex counter: `NUM_CH` independent counters of `NUM_CNT_BITS` each share one clock and reset. Each channel has up/down direction, periodic/one-shot mode, a level rollover flag, a single-cycle rollover pulse and a one-shot done flag. It serves as the shared timer and bit-counter bank for the SD/USB transmit and receive paths, for example bit-period timing, byte counting and timeout detection.

## Interface
- `NUM_CNT_BITS`, default 4: counter width per channel.
- `NUM_CH`, default 2: number of independent channels.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in NUM_CH: per-channel synchronous clear; dominates every other input.
- `count_enable` in NUM_CH: per-channel step request.
- `count_down` in NUM_CH: 1 selects down-count, 0 selects up-count; sampled every cycle.
- `one_shot` in NUM_CH: 1 means stop at the terminal value; 0 means periodic wrap.
- `rollover_val` in NUM_CH*NUM_CNT_BITS: channel i occupies bits [i*NUM_CNT_BITS +: NUM_CNT_BITS].
- `count_out` out NUM_CH*NUM_CNT_BITS: registered count, packed the same way.
- `rollover_flag` out NUM_CH: registered level; high while the count sits at the terminal value.
- `rollover_pulse` out NUM_CH: registered; high for one cycle per step into the terminal value.
- `done` out NUM_CH: registered; a one-shot channel has reached the terminal value and is halted.
- `any_rollover` out 1: OR of `rollover_pulse`, derived combinationally from registers only.

## Operation
Per channel, R = rollover_val slice, C = count.
- **Terminal value T:** T = R when counting up; T = 1 when counting down.
- **R = 0:** the channel is disabled. C is held, flag, pulse and done stay 0, and `count_enable` is ignored. `clear` still forces C to 0.
- **Priority:** `clear` > halted (`done` = 1) > `count_enable` > hold.
- **clear:** next C = 0; flag, pulse and done go to 0.
- **Up step:** if C >= R, next C = 1; otherwise next C = C + 1.
  - Sequence from 0 is 1, 2, …, R, 1, 2, …
  - If R is lowered below C, the next step wraps to 1.
- **Down step:** if C <= 1 or C > R, next C = R; otherwise next C = C − 1.
  - Sequence from 0 is R, R−1, …, 1, R, …
- **Arithmetic:** modulo 2^NUM_CNT_BITS. No overflow is possible, because up-count wraps at R <= 2^N−1.
- **Flag:** next flag = !clear && R != 0 && (next C == T), evaluated with the current-cycle direction. The flag is also updated on hold cycles, so a change of R or direction is reflected one cycle later.
- **Pulse:** next pulse = a step occurs this cycle (enabled, not cleared, not halted, R != 0) && next C == T.
  - With R = 1 in periodic up-count, C stays at 1 and the pulse repeats on every enabled cycle.
- **One-shot:** the step that raises the pulse also sets done. While done = 1, C is frozen and pulse = 0; flag follows the flag rule.
  - Only `clear` or `rst` releases a halted channel.
  - Deasserting `one_shot` while done = 1 does not release it.
- **Mode change:** a `count_down` change takes effect on the next step with no extra latency.
- **Channel independence:** channels share no state. Simultaneous events on different channels do not interact.

## Timing
- **Reset:** while `rst` = 1, all `count_out` = 0 and `rollover_flag`, `rollover_pulse`, `done`, `any_rollover` = 0, asynchronously. Reset asserted mid-count aborts immediately. The first possible step is the first rising edge after `rst` falls.
- **Latency:** one cycle from the input edge to `count_out`, flag, pulse and done. `any_rollover` has the same timing as the pulses.
- **No handshake:** `count_enable` is a level. Each high cycle at a rising edge is one step.

## Test plan
- **Reset:** reset mid-count (ch0 at C = 3) → all outputs 0 asynchronously. After release with R = 5 and enable held, C = 1, 2, 3, 4, 5, 1. Flag is high only at C = 5; pulse is a single cycle coincident with C = 5.
- **Down count:** ch1 down, periodic, R = 3, from 0 → C = 3, 2, 1, 3, 2, 1. Flag and pulse are high in the cycles C = 1. `any_rollover` tracks them.
- **One-shot:** ch0 one-shot up, R = 4 → C = 1..4, one pulse, then done = 1 and C holds at 4 under continued enable. Deasserting `one_shot` → no change. `clear` → C = 0, done = 0, then counting resumes.
- **Clear priority:** `clear` and `count_enable` both high at C = 4, R = 5 → C = 0 and flag 0. With R = 1 periodic → C = 1 every cycle and a pulse on every enabled cycle.
- **R boundaries:** R = 0 with enable → C stays 0 and no flags. R changed from 9 to 3 while C = 7 (up) → next C = 1.
- **Channel isolation:** NUM_CH = 4, NUM_CNT_BITS = 8. Ch2 R = 255 up, ch3 R = 255 down, others idle. Ch2 wraps 255 → 1 and ch3 runs 1 → 255, each with a single pulse per wrap. Idle channels remain 0 throughout.
